// File: rtl/spi_slave_rx_fifo.sv
// Receive-side FIFO between the SPI slave deserializer and the AXI plug.
// First-word fall-through output, occupancy counter and high-water mark.
module spi_slave_rx_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned AFULL_LEVEL  = BUFFER_DEPTH - 2
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic                              clear,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              data_in_valid,
  output logic                              data_in_ready,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              data_out_valid,
  input  logic                              data_out_ready,
  output logic [$clog2(BUFFER_DEPTH):0]     elements,
  output logic                              almost_full,
  output logic [$clog2(BUFFER_DEPTH):0]     max_level
);

  localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] elements_q, elements_d;
  logic [CNT_W-1:0] max_level_q, max_level_d;

  logic push, pop;

  // Handshake qualifiers; clear blocks both sides in its cycle.
  always_comb begin
    data_in_ready  = (elements_q != CNT_W'(BUFFER_DEPTH)) && !clear;
    data_out_valid = (elements_q != '0) && !clear;
    push           = data_in_valid && data_in_ready;
    pop            = data_out_valid && data_out_ready;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    elements_d  = elements_q;
    max_level_d = max_level_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      elements_d  = '0;
      max_level_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      elements_d = elements_q + CNT_W'(1);
      else if (pop && !push) elements_d = elements_q - CNT_W'(1);
      // High-water mark tracks the occupancy that the coming edge will produce.
      if (elements_d > max_level_q) max_level_d = elements_d;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      elements_q  <= '0;
      max_level_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      elements_q  <= elements_d;
      max_level_q <= max_level_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge axi_aclk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out    = mem_q[rd_ptr_q];
  assign elements    = elements_q;
  assign max_level   = max_level_q;
  assign almost_full = elements_q >= CNT_W'(AFULL_LEVEL);

endmodule
